// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types: mult/div FSM states, default occupancies,
// and the per-stage enable/flush bundle.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exme_en;
    logic mewb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exme_flush;
  } stage_ctl_t;

  function automatic stage_ctl_t ctl_fill(
    input logic en,
    input logic fl
  );
    stage_ctl_t c;
    c.pc_en      = en;
    c.ifid_en    = en;
    c.idex_en    = en;
    c.exme_en    = en;
    c.mewb_en    = en;
    c.ifid_flush = fl;
    c.idex_flush = fl;
    c.exme_flush = fl;
    return c;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall / branch-flush performance counters (wrap at 2^32).
// Built only when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_inc)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc)
        flush_count <= flush_count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables/flushes and mult/div occupancy FSM.
// Perf counters built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hz_stall,
  input  logic        br_redirect,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exme_en,
  output logic        mewb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exme_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

  md_state_t     state;
  md_state_t     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  logic mem_freeze;
  logic in_busy;
  logic done_i;
  logic md_frz;
  logic sel_rst;
  logic sel_mem;
  logic sel_md;
  logic sel_hz;
  logic sel_br;

  stage_ctl_t ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign mem_freeze = mem_req & ~mem_ready;
  assign in_busy    = (state == MD_BUSY);
  assign done_i     = in_busy & (cnt == '0);
  assign md_frz     = (~in_busy & md_start)
                    | (in_busy & ~done_i);

  // Mutually exclusive selects encode the request priority.
  assign sel_rst = rst;
  assign sel_mem = ~rst & mem_freeze;
  assign sel_md  = ~rst & ~mem_freeze & md_frz;
  assign sel_hz  = ~rst & ~mem_freeze & ~md_frz
                 & hz_stall;
  assign sel_br  = ~rst & ~mem_freeze & ~md_frz
                 & ~hz_stall & br_redirect;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      RUN: begin
        if (md_start && !mem_freeze) begin
          state_nx = MD_BUSY;
          cnt_nx   = md_is_div ? DIV_LD : MUL_LD;
        end
      end
      MD_BUSY: begin
        // Counting continues through a memory freeze.
        if (cnt != '0)
          cnt_nx = cnt - 1'b1;
        if (done_i && !mem_freeze)
          state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    ctl = ctl_fill(1'b1, 1'b0);
    unique case (1'b1)
      sel_rst: ctl = ctl_fill(1'b0, 1'b1);
      sel_mem: ctl = ctl_fill(1'b0, 1'b0);
      sel_md: begin
        ctl.pc_en      = 1'b0;
        ctl.ifid_en    = 1'b0;
        ctl.idex_en    = 1'b0;
        ctl.exme_en    = 1'b0;
        ctl.exme_flush = 1'b1;
      end
      sel_hz: begin
        ctl.pc_en      = 1'b0;
        ctl.ifid_en    = 1'b0;
        ctl.idex_flush = 1'b1;
      end
      sel_br:  ctl.ifid_flush = 1'b1;
      default: ctl = ctl_fill(1'b1, 1'b0);
    endcase
  end

  assign pc_en      = ctl.pc_en;
  assign ifid_en    = ctl.ifid_en;
  assign idex_en    = ctl.idex_en;
  assign exme_en    = ctl.exme_en;
  assign mewb_en    = ctl.mewb_en;
  assign ifid_flush = ctl.ifid_flush;
  assign idex_flush = ctl.idex_flush;
  assign exme_flush = ctl.exme_flush;

  assign md_busy = ~rst & in_busy;
  assign md_done = ~rst & done_i;

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_inc    (~rst & ~ctl.pc_en),
    .flush_inc    (sel_br),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for single-cycle
// priority, hand sequences for mult/div, reset abort, mem freeze.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hz_stall;
  logic        br_redirect;
  logic        md_start;
  logic        md_is_div;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exme_en;
  logic        mewb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exme_flush;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  pipe_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hz_stall     (hz_stall),
    .br_redirect  (br_redirect),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exme_en      (exme_en),
    .mewb_en      (mewb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exme_flush   (exme_flush),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // {pc, ifid, idex, exme, mewb, ifid_fl, idex_fl, exme_fl}
  wire [7:0] ctl = {pc_en, ifid_en, idex_en, exme_en,
                    mewb_en, ifid_flush, idex_flush,
                    exme_flush};
  // md freeze view: {pc, ifid, idex, mewb, exme_fl}
  wire [4:0] frz = {pc_en, ifid_en, idex_en, mewb_en,
                    exme_flush};

  localparam logic [7:0] C_NORM = 8'b11111_000;
  localparam logic [7:0] C_RST  = 8'b00000_111;
  localparam logic [7:0] C_MEM  = 8'b00000_000;
  localparam logic [4:0] F_MD   = 5'b00011;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_perf(input string nm);
`ifdef PIPE_CTRL_PERF_EN
    chk({nm, ".stall"}, stall_cycles, exp_stall);
    chk({nm, ".flush"}, flush_count, exp_flush);
`else
    chk({nm, ".stall"}, stall_cycles, 32'd0);
    chk({nm, ".flush"}, flush_count, 32'd0);
`endif
  endtask

  task automatic tick(input logic st, input logic fl,
                      input logic clr, input string nm);
    @(posedge clk);
    #1;
    if (clr) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (st) exp_stall++;
      if (fl) exp_flush++;
    end
    chk_perf(nm);
  endtask

  typedef struct {
    logic       hz;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [7:0] ctl;
    string      nm;
  } vec_t;

  vec_t vec[8];

  initial begin
    vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, C_NORM, "normal"};
    vec[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'b00111_010, "hz"};
    vec[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'b00111_010, "hz_br"};
    vec[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'b11111_100, "br"};
    vec[4] = '{1'b0, 1'b0, 1'b1, 1'b0, C_MEM, "memwait"};
    vec[5] = '{1'b0, 1'b0, 1'b1, 1'b1, C_NORM, "memrdy"};
    vec[6] = '{1'b1, 1'b1, 1'b1, 1'b0, C_MEM, "mem_hz_br"};
    vec[7] = '{1'b0, 1'b0, 1'b0, 1'b1, C_NORM, "rdy_only"};

    rst = 1'b1;
    hz_stall = 1'b0;
    br_redirect = 1'b0;
    md_start = 1'b0;
    md_is_div = 1'b0;
    mem_req = 1'b0;
    mem_ready = 1'b0;

    #1;
    chk("rst.ctl", 32'(ctl), 32'(C_RST));
    chk("rst.busy", 32'(md_busy), 0);
    chk("rst.done", 32'(md_done), 0);
    tick(1'b0, 1'b0, 1'b1, "rst");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      hz_stall    = vec[i].hz;
      br_redirect = vec[i].br;
      mem_req     = vec[i].mreq;
      mem_ready   = vec[i].mrdy;
      #1;
      chk({vec[i].nm, ".ctl"}, 32'(ctl), 32'(vec[i].ctl));
      chk({vec[i].nm, ".busy"}, 32'(md_busy), 0);
      tick(~vec[i].ctl[7], vec[i].ctl[2], 1'b0, vec[i].nm);
    end
    hz_stall = 1'b0;
    br_redirect = 1'b0;
    mem_req = 1'b0;
    mem_ready = 1'b0;

    // mult: accepted at k=0, done at k=4, RUN at k=5
    for (int k = 0; k <= 5; k++) begin
      md_start = (k == 0);
      md_is_div = 1'b0;
      #1;
      chk($sformatf("mul%0d.busy", k), 32'(md_busy),
          32'(k >= 1 && k <= 4));
      chk($sformatf("mul%0d.done", k), 32'(md_done),
          32'(k == 4));
      if (k <= 3)
        chk($sformatf("mul%0d.frz", k), 32'(frz), 32'(F_MD));
      else
        chk($sformatf("mul%0d.ctl", k), 32'(ctl), 32'(C_NORM));
      tick(k <= 3, 1'b0, 1'b0, "mul");
    end

    // div with memory wait over the done window
    for (int k = 0; k <= 35; k++) begin
      md_start = (k == 0);
      md_is_div = 1'b1;
      mem_req = (k >= 31 && k <= 33);
      mem_ready = 1'b0;
      #1;
      chk($sformatf("div%0d.busy", k), 32'(md_busy),
          32'(k >= 1 && k <= 34));
      chk($sformatf("div%0d.done", k), 32'(md_done),
          32'(k >= 32 && k <= 34));
      if (k >= 31 && k <= 33)
        chk($sformatf("div%0d.ctl", k), 32'(ctl), 32'(C_MEM));
      if (k == 34)
        chk("div34.ctl", 32'(ctl), 32'(C_NORM));
      tick(k <= 33, 1'b0, 1'b0, "div");
    end
    mem_req = 1'b0;

    // reset in the middle of a divide
    for (int k = 0; k <= 12; k++) begin
      md_start = (k == 0);
      md_is_div = 1'b1;
      rst = (k == 10);
      #1;
      chk($sformatf("abt%0d.done", k), 32'(md_done), 0);
      if (k == 10)
        chk("abt10.ctl", 32'(ctl), 32'(C_RST));
      if (k >= 10)
        chk($sformatf("abt%0d.busy", k), 32'(md_busy), 0);
      tick(k <= 9, 1'b0, k == 10, "abt");
    end
    rst = 1'b0;

    // md_start blocked by memory wait, accepted once ready
    md_start = 1'b1;
    md_is_div = 1'b0;
    mem_req = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("blk0.ctl", 32'(ctl), 32'(C_MEM));
    tick(1'b1, 1'b0, 1'b0, "blk0");
    chk("blk1.busy", 32'(md_busy), 0);
    mem_ready = 1'b1;
    #1;
    chk("blk1.frz", 32'(frz), 32'(F_MD));
    tick(1'b1, 1'b0, 1'b0, "blk1");
    md_start = 1'b0;
    mem_req = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("blk2.busy", 32'(md_busy), 1);
    for (int j = 0; j < 10; j++) begin
      if (md_done) break;
      tick(1'b1, 1'b0, 1'b0, "blk_wait");
    end
    chk("blk.done", 32'(md_done), 1);
    tick(1'b0, 1'b0, 1'b0, "blk_end");
    chk("blk.run", 32'(md_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
